add_arbiter: RTL and testbench

- Shares one 4-bit adder datapath (a+b -> {cout,sum}) between two requesters.
- Each requester uses a valid/ready handshake.
- Operands are latched on grant and the add is sequenced through a small FSM.
- The result is returned on one registered response channel, tagged with the requester id, with backpressure.
- Sits between two independent client blocks and the shared adder slice.

---
 rtl/add_arbiter_pkg.sv | 13 +
 rtl/add_arbiter_if.sv | 37 +++
 rtl/add_arbiter_adder.sv | 11 +
 rtl/add_arbiter.sv | 102 ++++++++++
 tb/tb_add_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the two-requester shared-adder arbiter.
package add_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/add_arbiter_if.sv
// Request/response bundle between the two clients, the consumer and add_arbiter.
interface add_arbiter_if;

  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_sum;
  logic       rsp_cout;
  logic       busy;

  // Clients and consumer side.
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

endinterface

// File: rtl/add_arbiter_adder.sv
// Shared 4-bit adder slice: {cout, sum} = a + b with the carry preserved.
module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add_arbiter.sv
// Arbitrates two valid/ready requesters onto one adder and returns a tagged,
// registered result with backpressure (IDLE -> EXEC -> RESP).
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic         clk,
  input  logic         rst_n,
  add_arbiter_if.slave bus
);

  state_t     state_q, state_d;
  logic       last_grant_q;
  logic [3:0] op_a_q, op_b_q;
  logic       op_id_q;

  logic       grant_id;
  logic       ready0, ready1, accept;
  logic [3:0] add_sum;
  logic       add_cout;

  logic       rsp_valid_q, rsp_id_q, rsp_cout_q;
  logic [3:0] rsp_sum_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant_id = (PRIO_MODE == PRIO_FIXED) ? 1'b0 : ~last_grant_q;
    else if (bus.req1_valid)
      grant_id = 1'b1;
  end

  assign ready0 = (state_q == ST_IDLE) && bus.req0_valid && !grant_id;
  assign ready1 = (state_q == ST_IDLE) && bus.req1_valid &&  grant_id;
  assign accept = ready0 || ready1;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept)        state_d = ST_EXEC;
      ST_EXEC:                    state_d = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: operand registers are reset too; last_grant starts at 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q       <= 4'h0;
      op_b_q       <= 4'h0;
      op_id_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      op_a_q       <= grant_id ? bus.req1_a : bus.req0_a;
      op_b_q       <= grant_id ? bus.req1_b : bus.req0_b;
      op_id_q      <= grant_id;
      last_grant_q <= grant_id;
    end
  end

  adder u_adder (
    .a    (op_a_q),
    .b    (op_b_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result fields keep their last value after retire; only rsp_valid clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= 4'h0;
      rsp_cout_q  <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= op_id_q;
      rsp_sum_q   <= add_sum;
      rsp_cout_q  <= add_cout;
    end else if (state_q == ST_RESP && bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_sum    = rsp_sum_q;
  assign bus.rsp_cout   = rsp_cout_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_add_arbiter.sv
// Cycle-by-cycle vector tables for both arbitration modes plus reset corner sequences.
module tb_add_arbiter;

  logic       clk;
  logic       rst_n;
  logic       v0, v1, rr;
  logic [3:0] a0, b0, a1, b1;

  int checks   = 0;
  int failures = 0;

  add_arbiter_if if_rr ();
  add_arbiter_if if_fx ();

  assign if_rr.req0_valid = v0;
  assign if_rr.req0_a     = a0;
  assign if_rr.req0_b     = b0;
  assign if_rr.req1_valid = v1;
  assign if_rr.req1_a     = a1;
  assign if_rr.req1_b     = b1;
  assign if_rr.rsp_ready  = rr;

  assign if_fx.req0_valid = v0;
  assign if_fx.req0_a     = a0;
  assign if_fx.req0_b     = b0;
  assign if_fx.req1_valid = v1;
  assign if_fx.req1_a     = a1;
  assign if_fx.req1_b     = b1;
  assign if_fx.rsp_ready  = rr;

  add_arbiter #(.PRIO_MODE(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(if_rr.slave));
  add_arbiter #(.PRIO_MODE(1)) u_fx (.clk(clk), .rst_n(rst_n), .bus(if_fx.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v0;
    logic [3:0] a0, b0;
    logic       v1;
    logic [3:0] a1, b1;
    logic       rr;
    logic       r0, r1, rv, id;
    logic [3:0] sum;
    logic       cout, busy;
  } vec_t;

  vec_t tab_rr [28];
  vec_t tab_fx [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {v0, v1, rr} = 3'b000;
    {a0, b0, a1, b1} = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one vector for one cycle and compare {r0,r1,rv,id,sum,cout,busy} before the edge.
  task automatic run_vec(input vec_t v, input bit use_fx, input string name);
    logic [9:0] act, exp;
    v0 = v.v0; a0 = v.a0; b0 = v.b0;
    v1 = v.v1; a1 = v.a1; b1 = v.b1;
    rr = v.rr;
    @(negedge clk);
    if (use_fx)
      act = {if_fx.req0_ready, if_fx.req1_ready, if_fx.rsp_valid, if_fx.rsp_id,
             if_fx.rsp_sum, if_fx.rsp_cout, if_fx.busy};
    else
      act = {if_rr.req0_ready, if_rr.req1_ready, if_rr.rsp_valid, if_rr.rsp_id,
             if_rr.rsp_sum, if_rr.rsp_cout, if_rr.busy};
    exp = {v.r0, v.r1, v.rv, v.id, v.sum, v.cout, v.busy};
    check(name, {22'h0, act}, {22'h0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // v0 a0 b0 v1 a1 b1 rr | r0 r1 rv id sum cout busy
    tab_rr[0]  = '{1'b1, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tab_rr[1]  = '{1'b0, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
    tab_rr[2]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1};
    tab_rr[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1};
    tab_rr[4]  = '{1'b0, 4'h0, 4'h0, 1'b1, 4'hF, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0};
    tab_rr[5]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7, 1'b0, 1'b1};
    tab_rr[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 1'b1};
    tab_rr[7]  = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0};
    tab_rr[8]  = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1};
    tab_rr[9]  = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1};
    tab_rr[10] = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0};
    tab_rr[11] = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b1};
    tab_rr[12] = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[13] = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0};
    tab_rr[14] = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[15] = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1};
    tab_rr[16] = '{1'b1, 4'h1, 4'h2, 1'b1, 4'h5, 4'h6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0};
    tab_rr[17] = '{1'b1, 4'h9, 4'h9, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 1'b1};
    tab_rr[18] = '{1'b1, 4'hA, 4'h5, 1'b1, 4'hE, 4'hE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[19] = '{1'b1, 4'h7, 4'h7, 1'b1, 4'hD, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[20] = '{1'b0, 4'h1, 4'h1, 1'b1, 4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[21] = '{1'b1, 4'h3, 4'h3, 1'b0, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[22] = '{1'b1, 4'h5, 4'h5, 1'b1, 4'h6, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[23] = '{1'b1, 4'h5, 4'h5, 1'b1, 4'h6, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[24] = '{1'b1, 4'h8, 4'h8, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b0};
    tab_rr[25] = '{1'b0, 4'h8, 4'h8, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0, 1'b1};
    tab_rr[26] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1};
    tab_rr[27] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};

    tab_fx[0]  = '{1'b1, 4'h2, 4'h3, 1'b1, 4'h7, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tab_fx[1]  = '{1'b1, 4'h2, 4'h3, 1'b1, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1};
    tab_fx[2]  = '{1'b1, 4'h2, 4'h3, 1'b1, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b1};
    tab_fx[3]  = '{1'b1, 4'h2, 4'h3, 1'b1, 4'h7, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
    tab_fx[4]  = '{1'b1, 4'h2, 4'h3, 1'b1, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1};
    tab_fx[5]  = '{1'b1, 4'h2, 4'h3, 1'b1, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, 1'b1};
    tab_fx[6]  = '{1'b0, 4'h2, 4'h3, 1'b1, 4'h7, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0};
    tab_fx[7]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h7, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 1'b0, 1'b1};
    tab_fx[8]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 1'b1};
    tab_fx[9]  = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h8, 1'b0, 1'b0};

    // Round-robin: single requests, wrap-around, alternation, backpressure.
    do_reset();
    for (int i = 0; i < 28; i++) run_vec(tab_rr[i], 1'b0, $sformatf("rr_vec%0d", i));

    // Fixed priority: req0 keeps winning until it drops.
    do_reset();
    for (int i = 0; i < 10; i++) run_vec(tab_fx[i], 1'b1, $sformatf("fx_vec%0d", i));

    // Reset while in EXEC: busy drops without waiting for a clock edge.
    do_reset();
    v0 = 1'b1; a0 = 4'h3; b0 = 4'h3;
    @(negedge clk);
    check("exec_ready0", {31'h0, if_rr.req0_ready}, 32'h1);
    @(posedge clk);
    #1 v0 = 1'b0;
    check("exec_busy", {31'h0, if_rr.busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("exec_rst_busy", {31'h0, if_rr.busy}, 32'h0);
    check("exec_rst_valid", {31'h0, if_rr.rsp_valid}, 32'h0);

    // Reset while in RESP: rsp_valid drops immediately.
    @(posedge clk);
    #1 rst_n = 1'b1;
    v0 = 1'b1; a0 = 4'h2; b0 = 4'h2; rr = 1'b0;
    @(posedge clk);
    #1 v0 = 1'b0;
    @(posedge clk);
    #1;
    check("resp_valid", {31'h0, if_rr.rsp_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("resp_rst_valid", {31'h0, if_rr.rsp_valid}, 32'h0);
    check("resp_rst_busy", {31'h0, if_rr.busy}, 32'h0);

    // After release, F+F from req0 completes with bounded wait and two-cycle latency.
    @(posedge clk);
    #1 rst_n = 1'b1;
    v0 = 1'b1; a0 = 4'hF; b0 = 4'hF; rr = 1'b1;
    @(negedge clk);
    check("ff_ready0", {31'h0, if_rr.req0_ready}, 32'h1);
    begin
      int lat;
      lat = 0;
      @(posedge clk);
      #1 v0 = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!if_rr.rsp_valid && lat < 6) begin
        @(negedge clk);
        lat++;
      end
      check("ff_latency", lat, 2);
    end
    check("ff_valid", {31'h0, if_rr.rsp_valid}, 32'h1);
    check("ff_id", {31'h0, if_rr.rsp_id}, 32'h0);
    check("ff_sum", {28'h0, if_rr.rsp_sum}, 32'hE);
    check("ff_cout", {31'h0, if_rr.rsp_cout}, 32'h1);
    @(posedge clk);
    #1;
    check("ff_idle", {31'h0, if_rr.busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
